// File: rtl/axi_slave_mem_pkg.sv
// Shared types for the AXI4 slave memory model: bus widths, response codes,
// burst encodings, master/slave bundles and the two engine state enums.
package axi_slave_mem_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_USER_WIDTH = 1;
  localparam int DATA_BYTES     = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT     = $clog2(DATA_BYTES);

  typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
  typedef logic [DATA_BYTES-1:0]     axi_strb_t;
  typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
  typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;
  typedef logic [AXI_USER_WIDTH-1:0] axi_user_t;
  typedef logic [7:0]                axi_len_t;
  typedef logic [2:0]                axi_size_t;
  typedef logic [1:0]                axi_resp_t;

  localparam axi_resp_t AXI_OKAY   = 2'b00;
  localparam axi_resp_t AXI_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_st_t;
  typedef enum logic       {R_IDLE, R_DATA} rd_st_t;

  typedef struct packed {
    axi_id_t    awid;
    axi_addr_t  awaddr;
    axi_len_t   awlen;
    axi_size_t  awsize;
    axi_burst_t awburst;
    logic       awvalid;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    logic       wvalid;
    logic       bready;
    axi_id_t    arid;
    axi_addr_t  araddr;
    axi_len_t   arlen;
    axi_size_t  arsize;
    axi_burst_t arburst;
    logic       arvalid;
    logic       rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_id_t   bid;
    axi_resp_t bresp;
    axi_user_t buser;
    logic      bvalid;
    logic      arready;
    axi_id_t   rid;
    axi_data_t rdata;
    axi_resp_t rresp;
    logic      rlast;
    axi_user_t ruser;
    logic      rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master (e.g. the DMA port) and the slave memory.
interface axi_slave_mem_if;
  import axi_slave_mem_pkg::*;

  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_slave_mem_burst_addr_nxt.sv
// Next beat address for an AXI burst: FIXED keeps the address, INCR and WRAP
// (WRAP is treated as INCR) step by the transfer size in bytes.
module axi_burst_addr_nxt
  import axi_slave_mem_pkg::*;
(
  input  axi_addr_t  addr,
  input  axi_size_t  size,
  input  axi_burst_t burst,
  output axi_addr_t  nxt
);

  // Step the address unless the burst is FIXED
  always_comb begin
    nxt = addr;
    if (burst != AXI_BURST_FIXED) nxt = addr + (axi_addr_t'(1) << size);
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory model with independent write and read engines, one
// outstanding transaction each. Memory contents are not reset.
// Optional macro AXI_SLAVE_MEM_ERR_EN: beats outside the mapped window are
// dropped / read as zero and answered with SLVERR instead of wrapping.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int        MEM_WORDS = 4096,
  parameter axi_addr_t BASE_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  axi_slave_mem_if.slave   axi
);

  localparam int IDX_W = $clog2(MEM_WORDS);
`ifdef AXI_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  axi_data_t mem [MEM_WORDS];

  // Word index relative to BASE_ADDR; upper bits drop so the array wraps
  function automatic logic [IDX_W-1:0] word_idx(axi_addr_t a);
    axi_addr_t off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> BYTE_SHIFT);
  endfunction

  // Window check; always true when the range check is compiled out
  function automatic logic in_range(axi_addr_t a);
    logic [AXI_ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !ERR_EN || (!diff[AXI_ADDR_WIDTH] &&
           ((diff[AXI_ADDR_WIDTH-1:0] >> (BYTE_SHIFT + IDX_W)) == '0));
  endfunction

  function automatic axi_data_t load_word(axi_addr_t a);
    return in_range(a) ? mem[word_idx(a)] : '0;
  endfunction

  // ---------------- write engine ----------------
  wr_st_t     w_st, w_st_nxt;
  axi_id_t    w_id;
  axi_addr_t  w_addr, w_addr_nxt;
  axi_len_t   w_len, w_beat;
  axi_size_t  w_size;
  axi_burst_t w_burst;
  logic       w_err;
  logic       awready, wready, bvalid;
  logic       aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_hs       = awready && axi.mosi.awvalid;
  assign w_hs        = wready && axi.mosi.wvalid;
  assign b_hs        = bvalid && axi.mosi.bready;
  assign w_last_beat = (w_beat == w_len);

  axi_burst_addr_nxt u_aw_nxt (.addr(w_addr), .size(w_size), .burst(w_burst), .nxt(w_addr_nxt));

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_st <= W_IDLE;
    else     w_st <= w_st_nxt;
  end

  // Write FSM transitions: address, data beats, then response
  always_comb begin
    w_st_nxt = w_st;
    unique case (w_st)
      W_IDLE:  if (aw_hs) w_st_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_st_nxt = W_RESP;
      W_RESP:  if (b_hs) w_st_nxt = W_IDLE;
      default: w_st_nxt = W_IDLE;
    endcase
  end

  // Write FSM handshake outputs; address ready held off while in reset
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_st)
      W_IDLE:  awready = !rst;
      W_DATA:  wready  = 1'b1;
      W_RESP:  bvalid  = 1'b1;
      default: ;
    endcase
  end

  // Latch the write command, then track beat address, count and sticky error
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_id    <= axi.mosi.awid;
      w_addr  <= axi.mosi.awaddr;
      w_len   <= axi.mosi.awlen;
      w_size  <= axi.mosi.awsize;
      w_burst <= axi.mosi.awburst;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr_nxt;
      w_beat <= w_beat + 8'd1;
      if ((axi.mosi.wlast != w_last_beat) || !in_range(w_addr)) w_err <= 1'b1;
    end
  end

  // Byte-enabled memory write for each accepted in-range beat
  always_ff @(posedge clk) begin
    if (w_hs && in_range(w_addr)) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (axi.mosi.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi.mosi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rd_st_t     r_st, r_st_nxt;
  axi_id_t    r_id;
  axi_addr_t  r_addr, r_addr_nxt;
  axi_len_t   r_len, r_beat;
  axi_size_t  r_size;
  axi_burst_t r_burst;
  axi_data_t  r_data;
  logic       r_err;
  logic       arready, rvalid;
  logic       ar_hs, r_hs, r_last;

  assign ar_hs  = arready && axi.mosi.arvalid;
  assign r_hs   = rvalid && axi.mosi.rready;
  assign r_last = (r_beat == r_len);

  axi_burst_addr_nxt u_ar_nxt (.addr(r_addr), .size(r_size), .burst(r_burst), .nxt(r_addr_nxt));

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_st <= R_IDLE;
    else     r_st <= r_st_nxt;
  end

  // Read FSM transitions: stay in R_DATA until the last beat is taken
  always_comb begin
    r_st_nxt = r_st;
    unique case (r_st)
      R_IDLE:  if (ar_hs) r_st_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last) r_st_nxt = R_IDLE;
      default: r_st_nxt = R_IDLE;
    endcase
  end

  // Read FSM handshake outputs; address ready held off while in reset
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_st)
      R_IDLE:  arready = !rst;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Load the beat register on AR and on each non-last R handshake; it holds
  // otherwise, so a stalled beat stays stable and old data wins a same-edge write
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_id    <= axi.mosi.arid;
      r_addr  <= axi.mosi.araddr;
      r_len   <= axi.mosi.arlen;
      r_size  <= axi.mosi.arsize;
      r_burst <= axi.mosi.arburst;
      r_beat  <= '0;
      r_data  <= load_word(axi.mosi.araddr);
      r_err   <= !in_range(axi.mosi.araddr);
    end else if (r_hs && !r_last) begin
      r_addr <= r_addr_nxt;
      r_beat <= r_beat + 8'd1;
      r_data <= load_word(r_addr_nxt);
      r_err  <= !in_range(r_addr_nxt);
    end
  end

  // Slave bundle: payload fields forced to zero whenever their valid is low
  always_comb begin
    axi.miso         = '0;
    axi.miso.awready = awready;
    axi.miso.wready  = wready;
    axi.miso.bvalid  = bvalid;
    axi.miso.bid     = bvalid ? w_id : '0;
    axi.miso.bresp   = (bvalid && w_err) ? AXI_SLVERR : AXI_OKAY;
    axi.miso.arready = arready;
    axi.miso.rvalid  = rvalid;
    axi.miso.rid     = rvalid ? r_id : '0;
    axi.miso.rdata   = rvalid ? r_data : '0;
    axi.miso.rresp   = (rvalid && r_err) ? AXI_SLVERR : AXI_OKAY;
    axi.miso.rlast   = rvalid && r_last;
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Testbench for axi_slave_mem: directed bursts plus randomized traffic,
// expected B/R responses queued by the drivers and checked by a monitor.
module tb_axi_slave_mem;
  import axi_slave_mem_pkg::*;

  localparam int          MEM_WORDS = 16;
  localparam logic [31:0] BASE_ADDR = 32'h0;
`ifdef AXI_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slave_mem_if bus ();

  axi_slave_mem #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk),
    .rst(rst),
    .axi(bus.slave)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;

  // ---------------- reference model ----------------
  function automatic longint beat_addr(logic [31:0] base, int i, int size, int burst);
    if (burst == 0) return longint'(base);
    return (longint'(base) + longint'(i) * (longint'(1) << size)) & 64'hFFFF_FFFF;
  endfunction

  function automatic bit m_oor(longint a);
    return ERR_EN && ((a < longint'(BASE_ADDR)) || (a >= longint'(BASE_ADDR) + MEM_WORDS * 4));
  endfunction

  function automatic int m_idx(longint a);
    return int'(((a - longint'(BASE_ADDR)) / 4) % MEM_WORDS);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    b_exp_t be;
    r_exp_t re;
    if (!rst) begin
      if (bus.miso.bvalid && bus.mosi.bready) begin
        if (b_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_b: got bvalid with bid %0h, expected none", bus.miso.bid);
        end else begin
          be = b_q.pop_front();
          check("bid", bus.miso.bid, be.id);
          check("bresp", bus.miso.bresp, be.resp);
          check("buser", bus.miso.buser, 0);
        end
      end
      if (bus.miso.rvalid) begin
        if (r_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_r: got rvalid with rdata %0h, expected none", bus.miso.rdata);
        end else begin
          re = r_q[0];
          check("rid", bus.miso.rid, re.id);
          check("rdata", bus.miso.rdata, re.data);
          check("rresp", bus.miso.rresp, re.resp);
          check("rlast", bus.miso.rlast, re.last);
          check("ruser", bus.miso.ruser, 0);
          if (bus.mosi.rready) r_q.delete(0);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input int which, input string nm);
    bit got;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      got = (which == 0) ? bus.miso.awready : (which == 1) ? bus.miso.wready : bus.miso.arready;
      @(posedge clk); #1;
      if (got) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL %s_timeout: ready not seen within 50 cycles", nm);
  endtask

  // early_last: -1 = wlast on the final beat, else the beat carrying wlast (may be > len: never)
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int early_last, input bit gaps);
    bit     bad;
    longint a;
    bit     lf;
    b_exp_t e;
    bad = 0;
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, i, size, burst);
      lf = (early_last >= 0) ? (i == early_last) : (i == len);
      if (lf != (i == len)) bad = 1;
      if (m_oor(a)) bad = 1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) model_mem[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
    end
    e.id = id; e.resp = bad ? 2'b10 : 2'b00;
    b_q.push_back(e);
    bus.mosi.awid    = id;
    bus.mosi.awaddr  = addr;
    bus.mosi.awlen   = len[7:0];
    bus.mosi.awsize  = size[2:0];
    bus.mosi.awburst = axi_burst_t'(burst[1:0]);
    bus.mosi.awvalid = 1'b1;
    wait_rdy(0, "aw");
    bus.mosi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) wait_cycle();
      bus.mosi.wdata  = wd[i];
      bus.mosi.wstrb  = ws[i];
      bus.mosi.wlast  = (early_last >= 0) ? (i == early_last) : (i == len);
      bus.mosi.wvalid = 1'b1;
      wait_rdy(1, "w");
      bus.mosi.wvalid = 1'b0;
      bus.mosi.wlast  = 1'b0;
    end
    for (int k = 0; k < 200 && b_q.size() != 0; k++) begin
      bus.mosi.bready = (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (k == 0) check("bvalid_latency", bus.miso.bvalid, 1);
      @(posedge clk); #1;
    end
    bus.mosi.bready = 1'b1;
    if (b_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL b_timeout: %0d responses outstanding, expected 0", b_q.size());
      b_q.delete();
    end
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst);
    longint a;
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      a      = beat_addr(addr, i, size, burst);
      e.id   = id;
      e.data = m_oor(a) ? 32'h0 : model_mem[m_idx(a)];
      e.resp = m_oor(a) ? 2'b10 : 2'b00;
      e.last = (i == len);
      r_q.push_back(e);
    end
    bus.mosi.rready  = 1'b0;
    bus.mosi.arid    = id;
    bus.mosi.araddr  = addr;
    bus.mosi.arlen   = len[7:0];
    bus.mosi.arsize  = size[2:0];
    bus.mosi.arburst = axi_burst_t'(burst[1:0]);
    bus.mosi.arvalid = 1'b1;
    wait_rdy(2, "ar");
    bus.mosi.arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int hold, input bit rnd);
    ar_issue(id, addr, len, size, burst);
    for (int k = 0; k < 2000 && r_q.size() != 0; k++) begin
      bus.mosi.rready = (k < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      @(negedge clk);
      if (k == 0) check("rvalid_latency", bus.miso.rvalid, 1);
      @(posedge clk); #1;
    end
    bus.mosi.rready = 1'b0;
    if (r_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL r_timeout: %0d beats outstanding, expected 0", r_q.size());
      r_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          len, size, burst;
    logic [31:0] addr;
    logic [3:0]  id;

    bus.mosi        = '0;
    bus.mosi.bready = 1'b1;
    repeat (3) wait_cycle();
    @(negedge clk);
    check("rst_bvalid", bus.miso.bvalid, 0);
    check("rst_rvalid", bus.miso.rvalid, 0);
    check("rst_wready", bus.miso.wready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready", bus.miso.awready, 1);
    check("rel_arready", bus.miso.arready, 1);
    check("rel_rdata", bus.miso.rdata, 0);
    @(posedge clk); #1;

    // fill every word so later reads are defined
    for (int i = 0; i < MEM_WORDS; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h1, BASE_ADDR, MEM_WORDS - 1, 2, 1, -1, 1'b0);

    // single-beat write and read-back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h3, 32'h10, 0, 2, 1, -1, 1'b0);
    do_read(4'h5, 32'h10, 0, 2, 1, 0, 1'b0);

    // INCR burst with write gaps and a stalled read
    for (int i = 0; i < 8; i++) begin wd[i] = i; ws[i] = 4'hF; end
    do_write(4'h6, 32'h100, 7, 2, 1, -1, 1'b1);
    do_read(4'h7, 32'h100, 7, 2, 1, 3, 1'b0);

    // byte strobes
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(4'h2, 32'h30, 0, 2, 1, -1, 1'b0);
    wd[0] = 32'h00000000; ws[0] = 4'h5;
    do_write(4'h2, 32'h30, 0, 2, 1, -1, 1'b0);
    do_read(4'h2, 32'h30, 0, 2, 1, 0, 1'b0);

    // FIXED burst: last beat wins, read returns it four times
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(4'h8, 32'h20, 3, 2, 0, -1, 1'b0);
    do_read(4'h9, 32'h20, 3, 2, 0, 1, 1'b0);

    // wlast early on beat 2 of 4, and wlast missing entirely
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'hA, 32'h24, 3, 2, 1, 2, 1'b0);
    do_write(4'hB, 32'h28, 1, 2, 1, 99, 1'b0);

    // reset in the middle of a stalled read burst
    ar_issue(4'hC, 32'h0, 7, 2, 1);
    repeat (3) wait_cycle();
    rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    r_q.delete();
    @(negedge clk);
    check("midrst_rvalid", bus.miso.rvalid, 0);
    check("midrst_arready", bus.miso.arready, 1);
    @(posedge clk); #1;
    do_read(4'hD, 32'h4, 3, 2, 1, 0, 1'b0);

    // word 16 of a 16-word memory: wraps, or SLVERR when range-checked
    do_read(4'hE, 32'h40, 0, 2, 1, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      len   = $urandom_range(0, 7);
      size  = $urandom_range(0, 2);
      burst = $urandom_range(0, 2);
      addr  = 32'($urandom_range(0, MEM_WORDS * 2 - 1)) << 2;
      id    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        do_write(id, addr, len, size, burst, -1, 1'b1);
      end else begin
        do_read(id, addr, len, size, burst, $urandom_range(0, 2), 1'b1);
      end
    end

    repeat (3) wait_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
